// File: rtl/acc_sequencer_if.sv
// Purpose: command handshake, ALU flag inputs and datapath strobes of acc_sequencer.
// Latency: none; a bundle of wires only.
// Backpressure: cmd_valid/cmd_ready, a command transfers when both are high at a clock edge.
interface acc_sequencer_if #(
  parameter int CNT_W = 4
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [CNT_W-1:0] cmd_cnt;
  logic             alu_cf;
  logic             alu_zf;
  logic             nLa;
  logic             nLb;
  logic             Ea;
  logic             Eu;
  logic             sub;
  logic             busy;
  logic             done;
  logic             flag_c;
  logic             flag_z;
  logic             err;
  logic [CNT_W-1:0] iter_left;

  // Host / datapath side: issues commands and reports ALU flags.
  modport master (
    output cmd_valid, cmd_op, cmd_cnt, alu_cf, alu_zf,
    input  cmd_ready, nLa, nLb, Ea, Eu, sub, busy, done, flag_c, flag_z, err, iter_left
  );

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_op, cmd_cnt, alu_cf, alu_zf,
    output cmd_ready, nLa, nLb, Ea, Eu, sub, busy, done, flag_c, flag_z, err, iter_left
  );
endinterface

// File: rtl/acc_sequencer.sv
// Purpose: expands one host command into registered A/B/ALU control strobes and captures ALU flags.
// Latency: NOP/reserved done at k+1, LDA/LDB/OUT at k+2, ADD/SUB at k+3, RPT N at k+1+2N.
// Backpressure: cmd_ready only in IDLE with rst low; at least one IDLE cycle between commands.
module acc_sequencer #(
  parameter int CNT_W          = 4,
  parameter bit ABORT_ON_CARRY = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  acc_sequencer_if.slave bus
);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LDA = 3'b001;
  localparam logic [2:0] OP_LDB = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_OUT = 3'b101;
  localparam logic [2:0] OP_RPT = 3'b110;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_OUTP    = 3'd2,
    S_COMPUTE = 3'd3,
    S_WRITE   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_op, w_op_nxt;
  logic             r_nla, w_nla_nxt;
  logic             r_nlb, w_nlb_nxt;
  logic             r_ea, w_ea_nxt;
  logic             r_eu, w_eu_nxt;
  logic             r_sub, w_sub_nxt;
  logic             r_done, w_done_nxt;
  logic             r_flag_c, w_flag_c_nxt;
  logic             r_flag_z, w_flag_z_nxt;
  logic             r_err, w_err_nxt;
  logic [CNT_W-1:0] r_iter, w_iter_nxt;
  logic [CNT_W-1:0] w_iter_dec;
  logic             w_cmd_ready;
  logic             w_accept;

  assign w_cmd_ready = (r_state == S_IDLE) && !rst;
  assign w_accept    = w_cmd_ready && bus.cmd_valid;
  assign w_iter_dec  = r_iter - CNT_ONE;

  // Next state and next (registered) strobe values; strobes default to inactive every cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_op_nxt     = r_op;
    w_nla_nxt    = 1'b1;
    w_nlb_nxt    = 1'b1;
    w_ea_nxt     = 1'b0;
    w_eu_nxt     = 1'b0;
    w_sub_nxt    = 1'b0;
    w_done_nxt   = 1'b0;
    w_flag_c_nxt = r_flag_c;
    w_flag_z_nxt = r_flag_z;
    w_err_nxt    = r_err;
    w_iter_nxt   = r_iter;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_op_nxt  = bus.cmd_op;
          w_err_nxt = 1'b0;
          case (bus.cmd_op)
            OP_NOP: begin w_state_nxt = S_DONE; w_done_nxt = 1'b1; end
            OP_LDA: begin w_state_nxt = S_LOAD; w_nla_nxt = 1'b0; end
            OP_LDB: begin w_state_nxt = S_LOAD; w_nlb_nxt = 1'b0; end
            OP_OUT: begin w_state_nxt = S_OUTP; w_ea_nxt = 1'b1; end
            OP_ADD: w_state_nxt = S_COMPUTE;
            OP_SUB: begin w_state_nxt = S_COMPUTE; w_sub_nxt = 1'b1; end
            OP_RPT: begin
              w_iter_nxt = bus.cmd_cnt;
              if (bus.cmd_cnt == CNT_ZERO) begin
                w_state_nxt = S_DONE;
                w_done_nxt  = 1'b1;
              end else begin
                w_state_nxt = S_COMPUTE;
              end
            end
            default: begin
              // Reserved opcode: complete immediately and flag it.
              w_state_nxt = S_DONE;
              w_done_nxt  = 1'b1;
              w_err_nxt   = 1'b1;
            end
          endcase
        end
      end
      S_LOAD, S_OUTP: begin
        w_state_nxt = S_DONE;
        w_done_nxt  = 1'b1;
      end
      S_COMPUTE: begin
        // ALU result has settled; put it on the bus and load it into A.
        w_state_nxt = S_WRITE;
        w_eu_nxt    = 1'b1;
        w_nla_nxt   = 1'b0;
        w_sub_nxt   = r_sub;
      end
      S_WRITE: begin
        w_flag_c_nxt = bus.alu_cf;
        w_flag_z_nxt = bus.alu_zf;
        if (r_op == OP_RPT) begin
          w_iter_nxt = w_iter_dec;
          if (ABORT_ON_CARRY && bus.alu_cf) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
            w_err_nxt   = 1'b1;
          end else if (w_iter_dec == CNT_ZERO) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_COMPUTE;
          end
        end else begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and output registers; synchronous reset drops any command in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= OP_NOP;
      r_nla    <= 1'b1;
      r_nlb    <= 1'b1;
      r_ea     <= 1'b0;
      r_eu     <= 1'b0;
      r_sub    <= 1'b0;
      r_done   <= 1'b0;
      r_flag_c <= 1'b0;
      r_flag_z <= 1'b0;
      r_err    <= 1'b0;
      r_iter   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_op     <= w_op_nxt;
      r_nla    <= w_nla_nxt;
      r_nlb    <= w_nlb_nxt;
      r_ea     <= w_ea_nxt;
      r_eu     <= w_eu_nxt;
      r_sub    <= w_sub_nxt;
      r_done   <= w_done_nxt;
      r_flag_c <= w_flag_c_nxt;
      r_flag_z <= w_flag_z_nxt;
      r_err    <= w_err_nxt;
      r_iter   <= w_iter_nxt;
    end
  end

  assign bus.cmd_ready = w_cmd_ready;
  assign bus.nLa       = r_nla;
  assign bus.nLb       = r_nlb;
  assign bus.Ea        = r_ea;
  assign bus.Eu        = r_eu;
  assign bus.sub       = r_sub;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = r_done;
  assign bus.flag_c    = r_flag_c;
  assign bus.flag_z    = r_flag_z;
  assign bus.err       = r_err;
  assign bus.iter_left = r_iter;

endmodule

// File: tb/tb_acc_sequencer.sv
// Purpose: directed self-checking bench for acc_sequencer.
// Latency: each task checks strobes cycle by cycle relative to the accept edge.
// Backpressure: commands are issued only once cmd_ready is seen, with a bounded wait.
module tb_acc_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   inv_viol = 0;

  acc_sequencer_if #(.CNT_W(4)) bus ();

  acc_sequencer #(.CNT_W(4), .ABORT_ON_CARRY(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Invariant monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.Ea && bus.Eu) inv_viol++;
      if (!bus.nLa && !bus.nLb) inv_viol++;
      if ((!bus.busy || bus.done) && (!bus.nLa || !bus.nLb || bus.Ea || bus.Eu || bus.sub)) inv_viol++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for cmd_ready, presents the command for one edge; returns in cycle k+1.
  task automatic issue(input logic [2:0] op, input logic [3:0] cnt);
    int budget = 40;
    while (bus.cmd_ready !== 1'b1 && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) begin
      n_checks++;
      $display("FAIL issue_ready_timeout: cmd_ready=%b required 1", bus.cmd_ready);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_cnt   = cnt;
    step();
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'b111;
    bus.cmd_cnt   = 4'hF;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    n_checks++; if (bus.nLa !== 1'b1 || bus.nLb !== 1'b1) $display("FAIL reset_nl: nLa=%b nLb=%b required 1 1", bus.nLa, bus.nLb); else n_pass++;
    n_checks++; if ({bus.Ea, bus.Eu, bus.sub, bus.done} !== 4'b0000) $display("FAIL reset_strobes: Ea/Eu/sub/done=%b required 0000", {bus.Ea, bus.Eu, bus.sub, bus.done}); else n_pass++;
    n_checks++; if ({bus.flag_c, bus.flag_z, bus.err, bus.busy} !== 4'b0000) $display("FAIL reset_flags: c/z/err/busy=%b required 0000", {bus.flag_c, bus.flag_z, bus.err, bus.busy}); else n_pass++;
    n_checks++; if (bus.iter_left !== 4'd0) $display("FAIL reset_iter: iter_left=%0d required 0", bus.iter_left); else n_pass++;
    n_checks++; if (bus.cmd_ready !== 1'b0) $display("FAIL reset_ready_in_rst: cmd_ready=%b required 0", bus.cmd_ready); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL reset_ready_after: cmd_ready=%b required 1", bus.cmd_ready); else n_pass++;
  endtask

  task automatic test_lda();
    issue(3'b001, 4'd0);
    n_checks++; if (bus.nLa !== 1'b0 || bus.nLb !== 1'b1 || bus.Eu !== 1'b0) $display("FAIL lda_c1: nLa/nLb/Eu=%b%b%b required 010", bus.nLa, bus.nLb, bus.Eu); else n_pass++;
    n_checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.cmd_ready !== 1'b0) $display("FAIL lda_c1_ctl: busy/done/rdy=%b%b%b required 100", bus.busy, bus.done, bus.cmd_ready); else n_pass++;
    step();
    n_checks++; if (bus.done !== 1'b1 || bus.nLa !== 1'b1) $display("FAIL lda_c2: done/nLa=%b%b required 11", bus.done, bus.nLa); else n_pass++;
    step();
    n_checks++; if (bus.cmd_ready !== 1'b1 || bus.done !== 1'b0) $display("FAIL lda_c3: rdy/done=%b%b required 10", bus.cmd_ready, bus.done); else n_pass++;
  endtask

  task automatic test_ldb_add();
    issue(3'b010, 4'd0);
    n_checks++; if (bus.nLb !== 1'b0 || bus.nLa !== 1'b1) $display("FAIL ldb_c1: nLb/nLa=%b%b required 01", bus.nLb, bus.nLa); else n_pass++;
    step(); step();
    bus.alu_cf = 1'b0; bus.alu_zf = 1'b0;
    issue(3'b011, 4'd0);
    n_checks++; if (bus.Eu !== 1'b0 || bus.sub !== 1'b0 || bus.nLa !== 1'b1) $display("FAIL add_c1: Eu/sub/nLa=%b%b%b required 001", bus.Eu, bus.sub, bus.nLa); else n_pass++;
    step();
    n_checks++; if (bus.Eu !== 1'b1 || bus.nLa !== 1'b0 || bus.sub !== 1'b0) $display("FAIL add_c2: Eu/nLa/sub=%b%b%b required 100", bus.Eu, bus.nLa, bus.sub); else n_pass++;
    step();
    n_checks++; if (bus.done !== 1'b1 || bus.Eu !== 1'b0) $display("FAIL add_c3: done/Eu=%b%b required 10", bus.done, bus.Eu); else n_pass++;
    n_checks++; if (bus.flag_c !== 1'b0 || bus.flag_z !== 1'b0) $display("FAIL add_flags: c/z=%b%b required 00", bus.flag_c, bus.flag_z); else n_pass++;
    step();
  endtask

  task automatic test_sub_out();
    issue(3'b100, 4'd0);
    n_checks++; if (bus.sub !== 1'b1 || bus.Eu !== 1'b0) $display("FAIL sub_c1: sub/Eu=%b%b required 10", bus.sub, bus.Eu); else n_pass++;
    step();
    bus.alu_zf = 1'b1;
    n_checks++; if (bus.sub !== 1'b1 || bus.Eu !== 1'b1 || bus.nLa !== 1'b0) $display("FAIL sub_c2: sub/Eu/nLa=%b%b%b required 110", bus.sub, bus.Eu, bus.nLa); else n_pass++;
    step();
    bus.alu_zf = 1'b0;
    n_checks++; if (bus.done !== 1'b1 || bus.flag_z !== 1'b1 || bus.flag_c !== 1'b0) $display("FAIL sub_done: done/z/c=%b%b%b required 110", bus.done, bus.flag_z, bus.flag_c); else n_pass++;
    step();
    issue(3'b101, 4'd0);
    n_checks++; if (bus.Ea !== 1'b1 || bus.Eu !== 1'b0) $display("FAIL out_c1: Ea/Eu=%b%b required 10", bus.Ea, bus.Eu); else n_pass++;
    step();
    n_checks++; if (bus.Ea !== 1'b0 || bus.done !== 1'b1 || bus.flag_z !== 1'b1) $display("FAIL out_c2: Ea/done/z=%b%b%b required 011", bus.Ea, bus.done, bus.flag_z); else n_pass++;
    step();
  endtask

  task automatic test_rpt();
    logic [3:0] exp_iter [7] = '{4'd3, 4'd3, 4'd2, 4'd2, 4'd1, 4'd1, 4'd0};
    logic [6:0] exp_eu   = 7'b0101010;
    logic [6:0] exp_done = 7'b1000000;
    bus.alu_cf = 1'b0; bus.alu_zf = 1'b0;
    issue(3'b110, 4'd3);
    for (int c = 0; c < 7; c++) begin
      n_checks++; if (bus.Eu !== exp_eu[c] || bus.nLa !== !exp_eu[c]) $display("FAIL rpt3_strobe c%0d: Eu/nLa=%b%b required %b%b", c + 1, bus.Eu, bus.nLa, exp_eu[c], !exp_eu[c]); else n_pass++;
      n_checks++; if (bus.iter_left !== exp_iter[c] || bus.done !== exp_done[c]) $display("FAIL rpt3_iter c%0d: iter/done=%0d/%b required %0d/%b", c + 1, bus.iter_left, bus.done, exp_iter[c], exp_done[c]); else n_pass++;
      if (c < 6) step();
    end
    n_checks++; if (bus.flag_z !== 1'b0 || bus.err !== 1'b0) $display("FAIL rpt3_flags: z/err=%b%b required 00", bus.flag_z, bus.err); else n_pass++;
    step();
    issue(3'b110, 4'd0);
    n_checks++; if (bus.done !== 1'b1 || bus.Eu !== 1'b0 || bus.nLa !== 1'b1 || bus.iter_left !== 4'd0) $display("FAIL rpt0: done/Eu/nLa/iter=%b%b%b/%0d required 101/0", bus.done, bus.Eu, bus.nLa, bus.iter_left); else n_pass++;
    step();
  endtask

  task automatic test_rpt_abort();
    issue(3'b110, 4'd5);
    step(); step(); step();
    bus.alu_cf = 1'b1;
    n_checks++; if (bus.Eu !== 1'b1 || bus.iter_left !== 4'd4) $display("FAIL abort_c4: Eu/iter=%b/%0d required 1/4", bus.Eu, bus.iter_left); else n_pass++;
    step();
    bus.alu_cf = 1'b0;
    n_checks++; if (bus.done !== 1'b1 || bus.err !== 1'b1) $display("FAIL abort_c5: done/err=%b%b required 11", bus.done, bus.err); else n_pass++;
    n_checks++; if (bus.iter_left !== 4'd3 || bus.flag_c !== 1'b1) $display("FAIL abort_state: iter/c=%0d/%b required 3/1", bus.iter_left, bus.flag_c); else n_pass++;
    step();
    n_checks++; if (bus.err !== 1'b1) $display("FAIL abort_sticky: err=%b required 1", bus.err); else n_pass++;
    issue(3'b000, 4'd0);
    n_checks++; if (bus.done !== 1'b1 || bus.err !== 1'b0 || bus.flag_c !== 1'b1) $display("FAIL nop_clear: done/err/c=%b%b%b required 101", bus.done, bus.err, bus.flag_c); else n_pass++;
    step();
  endtask

  task automatic test_back_to_back();
    // Hold valid across completion; second acceptance must wait for an IDLE cycle.
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'b000; bus.cmd_cnt = 4'd0;
    step();
    n_checks++; if (bus.done !== 1'b1 || bus.cmd_ready !== 1'b0) $display("FAIL b2b_c1: done/rdy=%b%b required 10", bus.done, bus.cmd_ready); else n_pass++;
    step();
    n_checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) $display("FAIL b2b_c2: done/busy/rdy=%b%b%b required 001", bus.done, bus.busy, bus.cmd_ready); else n_pass++;
    step();
    bus.cmd_valid = 1'b0;
    n_checks++; if (bus.done !== 1'b1) $display("FAIL b2b_c3: done=%b required 1", bus.done); else n_pass++;
    step();
  endtask

  task automatic test_reserved_and_mid_reset();
    issue(3'b111, 4'd0);
    n_checks++; if (bus.done !== 1'b1 || bus.err !== 1'b1 || bus.nLa !== 1'b1 || bus.Ea !== 1'b0 || bus.Eu !== 1'b0) $display("FAIL reserved: done/err/nLa/Ea/Eu=%b%b%b%b%b required 11100", bus.done, bus.err, bus.nLa, bus.Ea, bus.Eu); else n_pass++;
    step();
    issue(3'b110, 4'd3);
    step();
    n_checks++; if (bus.Eu !== 1'b1 || bus.nLa !== 1'b0) $display("FAIL midrst_write: Eu/nLa=%b%b required 10", bus.Eu, bus.nLa); else n_pass++;
    rst = 1'b1;
    step();
    n_checks++; if (bus.nLa !== 1'b1 || bus.Eu !== 1'b0 || bus.busy !== 1'b0) $display("FAIL midrst_strobes: nLa/Eu/busy=%b%b%b required 100", bus.nLa, bus.Eu, bus.busy); else n_pass++;
    n_checks++; if (bus.flag_c !== 1'b0 || bus.flag_z !== 1'b0 || bus.iter_left !== 4'd0 || bus.cmd_ready !== 1'b0) $display("FAIL midrst_state: c/z/iter/rdy=%b%b/%0d/%b required 00/0/0", bus.flag_c, bus.flag_z, bus.iter_left, bus.cmd_ready); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL midrst_ready: cmd_ready=%b required 1", bus.cmd_ready); else n_pass++;
    step();
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'b000;
    bus.cmd_cnt   = 4'd0;
    bus.alu_cf    = 1'b0;
    bus.alu_zf    = 1'b0;
    test_reset();
    test_lda();
    test_ldb_add();
    test_sub_out();
    test_rpt();
    test_rpt_abort();
    test_back_to_back();
    test_reserved_and_mid_reset();
    n_checks++; if (inv_viol !== 0) $display("FAIL invariants: violations=%0d required 0", inv_viol); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
